// File: rtl/rename_map.sv
// Four-wide register rename: speculative RAT plus circular free list, with
// committed-map (ARAT) tracking for flush recovery.
module rename_map #(
  parameter int unsigned NARCH = 32,
  parameter int unsigned NPHY  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Stall,
  input  logic                        flush,
  input  logic                        RN_Inst1_Valid,
  input  logic                        RN_Inst2_Valid,
  input  logic                        RN_Inst3_Valid,
  input  logic                        RN_Inst4_Valid,
  input  logic                        RN_Inst1_RegWrite,
  input  logic                        RN_Inst2_RegWrite,
  input  logic                        RN_Inst3_RegWrite,
  input  logic                        RN_Inst4_RegWrite,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst1_Src1,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst2_Src1,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst3_Src1,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst4_Src1,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst1_Src2,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst2_Src2,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst3_Src2,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst4_Src2,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst1_Rdst,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst2_Rdst,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst3_Rdst,
  input  logic [$clog2(NARCH)-1:0]    RN_Inst4_Rdst,
  output logic [$clog2(NPHY)-1:0]     RE_Inst1_RSrc1,
  output logic [$clog2(NPHY)-1:0]     RE_Inst2_RSrc1,
  output logic [$clog2(NPHY)-1:0]     RE_Inst3_RSrc1,
  output logic [$clog2(NPHY)-1:0]     RE_Inst4_RSrc1,
  output logic [$clog2(NPHY)-1:0]     RE_Inst1_RSrc2,
  output logic [$clog2(NPHY)-1:0]     RE_Inst2_RSrc2,
  output logic [$clog2(NPHY)-1:0]     RE_Inst3_RSrc2,
  output logic [$clog2(NPHY)-1:0]     RE_Inst4_RSrc2,
  output logic [$clog2(NPHY)-1:0]     RE_Inst1_Phydst,
  output logic [$clog2(NPHY)-1:0]     RE_Inst2_Phydst,
  output logic [$clog2(NPHY)-1:0]     RE_Inst3_Phydst,
  output logic [$clog2(NPHY)-1:0]     RE_Inst4_Phydst,
  output logic                        RE_Stall,
  output logic [$clog2(NPHY):0]       RE_FreeCount,
  input  logic                        Cm_Inst1_Valid,
  input  logic                        Cm_Inst2_Valid,
  input  logic                        Cm_Inst3_Valid,
  input  logic                        Cm_Inst4_Valid,
  input  logic [$clog2(NARCH)-1:0]    Cm_Inst1_Rdst,
  input  logic [$clog2(NARCH)-1:0]    Cm_Inst2_Rdst,
  input  logic [$clog2(NARCH)-1:0]    Cm_Inst3_Rdst,
  input  logic [$clog2(NARCH)-1:0]    Cm_Inst4_Rdst,
  input  logic [$clog2(NPHY)-1:0]     Cm_Inst1_Phydst,
  input  logic [$clog2(NPHY)-1:0]     Cm_Inst2_Phydst,
  input  logic [$clog2(NPHY)-1:0]     Cm_Inst3_Phydst,
  input  logic [$clog2(NPHY)-1:0]     Cm_Inst4_Phydst,
  input  logic [$clog2(NPHY)-1:0]     Cm_Inst1_OldPhy,
  input  logic [$clog2(NPHY)-1:0]     Cm_Inst2_OldPhy,
  input  logic [$clog2(NPHY)-1:0]     Cm_Inst3_OldPhy,
  input  logic [$clog2(NPHY)-1:0]     Cm_Inst4_OldPhy
);

  localparam int unsigned AW    = $clog2(NARCH);
  localparam int unsigned PW    = $clog2(NPHY);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned NSLOT = 4;

  typedef logic [NARCH-1:0][PW-1:0] amap_t;
  typedef logic [NPHY-1:0][PW-1:0]  flist_t;

  // Identity map: every architectural register starts on its own physical one.
  function automatic amap_t map_init();
    amap_t m;
    for (int unsigned i = 0; i < NARCH; i++) m[i] = PW'(i);
    return m;
  endfunction

  function automatic flist_t fl_init();
    flist_t f;
    for (int unsigned j = 0; j < NPHY; j++)
      f[j] = (j < NPHY - NARCH) ? PW'(NARCH + j) : '0;
    return f;
  endfunction

  logic [NSLOT-1:0]          w_rn_v, w_rn_rw, w_cm_v, w_needy;
  logic [NSLOT-1:0][AW-1:0]  w_src1, w_src2, w_rdst, w_cm_rdst;
  logic [NSLOT-1:0][PW-1:0]  w_cm_phy, w_cm_old;
  logic [NSLOT-1:0][PW-1:0]  w_phy, w_rsrc1, w_rsrc2;
  logic [2:0]                w_k;
  logic [CW-1:0]             w_count;
  logic                      w_alloc;

  amap_t         r_rat, r_arat, w_rat_nxt, w_arat_nxt;
  flist_t        r_fl, w_fl_nxt;
  logic [CW-1:0] r_head, r_chead, r_tail;
  logic [CW-1:0] w_head_nxt, w_chead_nxt, w_tail_nxt;

  assign w_rn_v    = {RN_Inst4_Valid, RN_Inst3_Valid, RN_Inst2_Valid, RN_Inst1_Valid};
  assign w_rn_rw   = {RN_Inst4_RegWrite, RN_Inst3_RegWrite, RN_Inst2_RegWrite, RN_Inst1_RegWrite};
  assign w_src1    = {RN_Inst4_Src1, RN_Inst3_Src1, RN_Inst2_Src1, RN_Inst1_Src1};
  assign w_src2    = {RN_Inst4_Src2, RN_Inst3_Src2, RN_Inst2_Src2, RN_Inst1_Src2};
  assign w_rdst    = {RN_Inst4_Rdst, RN_Inst3_Rdst, RN_Inst2_Rdst, RN_Inst1_Rdst};
  assign w_cm_v    = {Cm_Inst4_Valid, Cm_Inst3_Valid, Cm_Inst2_Valid, Cm_Inst1_Valid};
  assign w_cm_rdst = {Cm_Inst4_Rdst, Cm_Inst3_Rdst, Cm_Inst2_Rdst, Cm_Inst1_Rdst};
  assign w_cm_phy  = {Cm_Inst4_Phydst, Cm_Inst3_Phydst, Cm_Inst2_Phydst, Cm_Inst1_Phydst};
  assign w_cm_old  = {Cm_Inst4_OldPhy, Cm_Inst3_OldPhy, Cm_Inst2_OldPhy, Cm_Inst1_OldPhy};

  // Destination allocation and source mapping with intra-group bypass.
  always_comb begin
    w_needy = '0;
    w_phy   = '0;
    w_rsrc1 = '0;
    w_rsrc2 = '0;
    w_k     = '0;
    for (int unsigned n = 0; n < NSLOT; n++) begin
      w_needy[n] = w_rn_v[n] & w_rn_rw[n] & (w_rdst[n] != '0);
      if (w_needy[n]) begin
        w_phy[n] = r_fl[PW'(r_head + CW'(w_k))];
        w_k      = w_k + 3'd1;
      end
    end
    for (int unsigned n = 0; n < NSLOT; n++) begin
      w_rsrc1[n] = (w_src1[n] == '0) ? '0 : r_rat[w_src1[n]];
      w_rsrc2[n] = (w_src2[n] == '0) ? '0 : r_rat[w_src2[n]];
      // Ascending scan so the youngest older writer overrides.
      for (int unsigned m = 0; m < n; m++) begin
        if (w_needy[m] && (w_src1[n] != '0) && (w_rdst[m] == w_src1[n])) w_rsrc1[n] = w_phy[m];
        if (w_needy[m] && (w_src2[n] != '0) && (w_rdst[m] == w_src2[n])) w_rsrc2[n] = w_phy[m];
      end
    end
  end

  assign w_count      = r_tail - r_head;
  assign RE_FreeCount = w_count;
  assign RE_Stall     = (w_count < CW'(w_k));
  assign w_alloc      = ~Stall & ~RE_Stall & ~flush;

  assign RE_Inst1_Phydst = w_phy[0];
  assign RE_Inst2_Phydst = w_phy[1];
  assign RE_Inst3_Phydst = w_phy[2];
  assign RE_Inst4_Phydst = w_phy[3];
  assign RE_Inst1_RSrc1  = w_rsrc1[0];
  assign RE_Inst2_RSrc1  = w_rsrc1[1];
  assign RE_Inst3_RSrc1  = w_rsrc1[2];
  assign RE_Inst4_RSrc1  = w_rsrc1[3];
  assign RE_Inst1_RSrc2  = w_rsrc2[0];
  assign RE_Inst2_RSrc2  = w_rsrc2[1];
  assign RE_Inst3_RSrc2  = w_rsrc2[2];
  assign RE_Inst4_RSrc2  = w_rsrc2[3];

  // Commit: release old mappings into the free list, advance committed map.
  always_comb begin
    w_arat_nxt  = r_arat;
    w_fl_nxt    = r_fl;
    w_tail_nxt  = r_tail;
    w_chead_nxt = r_chead;
    for (int unsigned n = 0; n < NSLOT; n++) begin
      if (w_cm_v[n] && (w_cm_rdst[n] != '0)) begin
        w_fl_nxt[PW'(w_tail_nxt)]  = w_cm_old[n];
        w_tail_nxt                 = w_tail_nxt + CW'(1);
        w_arat_nxt[w_cm_rdst[n]]   = w_cm_phy[n];
        w_chead_nxt                = w_chead_nxt + CW'(1);
      end
    end
  end

  // Speculative map: flush restores post-commit state, otherwise allocate.
  always_comb begin
    w_rat_nxt  = r_rat;
    w_head_nxt = r_head;
    if (flush) begin
      w_rat_nxt  = w_arat_nxt;
      w_head_nxt = w_chead_nxt;
    end else if (w_alloc) begin
      w_head_nxt = r_head + CW'(w_k);
      for (int unsigned n = 0; n < NSLOT; n++)
        if (w_needy[n]) w_rat_nxt[w_rdst[n]] = w_phy[n];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rat   <= map_init();
      r_arat  <= map_init();
      r_fl    <= fl_init();
      r_head  <= '0;
      r_chead <= '0;
      r_tail  <= CW'(NPHY - NARCH);
    end else begin
      r_rat   <= w_rat_nxt;
      r_arat  <= w_arat_nxt;
      r_fl    <= w_fl_nxt;
      r_head  <= w_head_nxt;
      r_chead <= w_chead_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

endmodule
